// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 widths and encodings for the read-responder slice.
package axi4_globals_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int DATA_BYTES    = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi4_burst_addr_gen
    import axi4_globals_pkg::*;
(
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [7:0]               len,
    input  logic [2:0]               size,
    input  logic [1:0]               burst,
    output logic [ADDRESS_WIDTH-1:0] next_addr
);

    logic [ADDRESS_WIDTH-1:0] step;
    logic [ADDRESS_WIDTH-1:0] incr;
    logic [ADDRESS_WIDTH-1:0] wrap_mask;

    assign step      = ADDRESS_WIDTH'(1) << size;
    assign incr      = addr + step;
    assign wrap_mask = ((ADDRESS_WIDTH'(len) + ADDRESS_WIDTH'(1)) << size) - ADDRESS_WIDTH'(1);

    // The reserved encoding 2'b11 falls through to INCR stepping.
    always_comb begin
        next_addr = incr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:     next_addr = incr;
        endcase
    end

endmodule

// File: rtl/axi4_slave_rd_responder.sv
// AXI4 read-channel slave, one outstanding burst, one memory read per beat.
// Define AXI4_SLAVE_RD_ERR_CHECK_EN to enable SLVERR/DECERR responses.
//
// state   | meaning
// IDLE    | arready high, waiting for a read request
// FETCH   | issue the memory read for the current beat (suppressed on error)
// CAPTURE | memory data arrives; register it into the R channel
// RESP    | rvalid held until rready, then next beat or back to IDLE
module axi4_slave_rd_responder
    import axi4_globals_pkg::*;
#(
    parameter longint unsigned MEM_BASE  = 0,
    parameter longint unsigned MEM_BYTES = 4096
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [3:0]               arid,
    input  logic [ADDRESS_WIDTH-1:0] araddr,
    input  logic [7:0]               arlen,
    input  logic [2:0]               arsize,
    input  logic [1:0]               arburst,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [3:0]               rid,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [1:0]               rresp,
    output logic                     rlast,
    output logic                     rvalid,
    input  logic                     rready,
    output logic                     mem_rd_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]               state;
    logic [3:0]               id_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [7:0]               len_q;
    logic [2:0]               size_q;
    logic [1:0]               burst_q;
    logic [1:0]               resp_q;
    logic [7:0]               beat_q;
    logic [ADDRESS_WIDTH-1:0] next_addr;
    logic                     in_range;
    axi_resp_t                ar_resp;

    assign in_range = (64'(araddr) >= MEM_BASE) && (64'(araddr) < MEM_BASE + MEM_BYTES);

`ifdef AXI4_SLAVE_RD_ERR_CHECK_EN
    always_comb begin
        ar_resp = RESP_OKAY;
        if ((arburst == 2'b11) ||
            ((arburst == BURST_WRAP) && !wrap_len_ok(arlen)) ||
            ((32'(1) << arsize) > 32'(DATA_BYTES)))
            ar_resp = RESP_SLVERR;
        else if (!in_range)
            ar_resp = RESP_DECERR;
    end
`else
    logic unused_cfg;
    assign unused_cfg = in_range;
    assign ar_resp    = RESP_OKAY;
`endif

    axi4_burst_addr_gen u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    assign arready   = (state == IDLE) && !areset;
    assign mem_rd_en = (state == FETCH) && (resp_q == RESP_OKAY);
    assign mem_addr  = mem_rd_en ? (addr_q & ~ADDRESS_WIDTH'(DATA_BYTES - 1)) : '0;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            resp_q  <= '0;
            beat_q  <= '0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            rlast   <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arvalid) begin
                        id_q    <= arid;
                        addr_q  <= araddr;
                        len_q   <= arlen;
                        size_q  <= arsize;
                        burst_q <= arburst;
                        resp_q  <= ar_resp;
                        beat_q  <= '0;
                        state   <= FETCH;
                    end
                end
                FETCH: state <= CAPTURE;
                CAPTURE: begin
                    rdata  <= (resp_q == RESP_OKAY) ? mem_rdata : '0;
                    rid    <= id_q;
                    rresp  <= resp_q;
                    rlast  <= (beat_q == len_q);
                    rvalid <= 1'b1;
                    state  <= RESP;
                end
                RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (rlast) begin
                            state <= IDLE;
                        end else begin
                            addr_q <= next_addr;
                            beat_q <= beat_q + 8'd1;
                            state  <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4_slave_rd_responder.md
AXI4_SLAVE_RD_RESPONDER -- requirements
Module: axi4_slave_rd_responder

Interface
REQ-001 The block SHALL have parameter MEM_BASE, default 0, meaning the first byte address decoded by the responder.
REQ-002 The block SHALL have parameter MEM_BYTES, default 4096, meaning the decoded region size in bytes.
REQ-003 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports arid, araddr, arlen, arsize, arburst and arvalid, all inputs, widths 4, ADDRESS_WIDTH, 8, 3, 2 and 1: the read address request.
REQ-006 The block SHALL have port arready, output, 1 bit: the read address handshake ready.
REQ-007 The block SHALL have ports rid, rdata, rresp, rlast and rvalid, all outputs, widths 4, DATA_WIDTH, 2, 1 and 1: the read data beat.
REQ-008 The block SHALL have port rready, input, 1 bit: the read data handshake ready.
REQ-009 The block SHALL have ports mem_rd_en and mem_addr, outputs, widths 1 and ADDRESS_WIDTH: the backing-memory read request, byte address aligned to DATA_WIDTH/8.
REQ-010 The block SHALL have port mem_rdata, input, DATA_WIDTH: memory data, valid exactly one cycle after mem_rd_en.

Function
REQ-011 The block SHALL support one outstanding burst with FSM states IDLE, FETCH, CAPTURE and RESP.
REQ-012 In IDLE, arready SHALL be 1; on arvalid&&arready the block SHALL latch arid, araddr, arlen, arsize and arburst, compute the error code (REQ-018) and go to FETCH.
REQ-013 In FETCH, the block SHALL pulse mem_rd_en=1 with mem_addr set to the beat address aligned down to the bus width, then go to CAPTURE; for an error burst mem_rd_en SHALL stay 0.
REQ-014 At the end of CAPTURE, the block SHALL register mem_rdata into rdata (zero for an error burst) and go to RESP; rvalid SHALL rise on entry to RESP.
REQ-015 In RESP, rvalid, rdata, rid, rresp and rlast SHALL stay stable until rready=1; on the handshake the block SHALL return to IDLE if rlast=1, otherwise go to FETCH, so a beat takes at least 3 cycles.
REQ-016 rlast SHALL be 1 only on beat arlen (beats are numbered 0..arlen, with an 8-bit beat counter).
REQ-017 The next beat address SHALL be: FIXED (2'b00) unchanged; INCR (2'b01) addr+(1<<arsize), carry discarded at ADDRESS_WIDTH; WRAP (2'b10) incremented within a boundary of (arlen+1)<<arsize bytes aligned to that size, wrapping to the boundary base.
REQ-018 Error checks SHALL give rresp SLVERR (2'b10) if arburst==2'b11, if WRAP has arlen not in {1,3,7,15}, or if (1<<arsize) exceeds DATA_WIDTH/8; otherwise DECERR (2'b11) if araddr is outside [MEM_BASE, MEM_BASE+MEM_BYTES); otherwise OKAY (2'b00).
REQ-019 The error code SHALL apply to every beat of the burst, and the full arlen+1 beats SHALL still be returned.
REQ-020 arready SHALL be 0 in FETCH, CAPTURE and RESP; an arvalid held high during a burst SHALL be accepted in the first IDLE cycle after the burst.

Reset
REQ-021 areset SHALL force IDLE immediately, and every output SHALL go to 0 except arready, which SHALL be 1 once reset deasserts.
REQ-022 Reset mid-burst SHALL drop the burst silently, with no further beats and rlast not asserted.

Configuration
REQ-023 With AXI4_SLAVE_RD_ERR_CHECK_EN defined, REQ-018 SHALL apply; without it, rresp SHALL be OKAY on every beat and memory SHALL be read for every burst, with addresses computed as INCR when arburst==2'b11.

Structure
REQ-024 ADDRESS_WIDTH, DATA_WIDTH, the burst-type enum (FIXED/INCR/WRAP) and the response enum (OKAY/EXOKAY/SLVERR/DECERR) SHALL come from axi4_globals_pkg; the FSM state enum SHALL be local.
REQ-025 The next-address computation SHALL be one combinational sub-module, axi4_burst_addr_gen (inputs: addr, len, size, burst; output: next_addr).

Verification
REQ-026 INCR, araddr=0x100, arlen=3, arsize=2 (32-bit bus), rready=1 -> mem_addr 0x100, 0x104, 0x108, 0x10C; 4 beats with rresp OKAY; rlast on beat 3 only.
REQ-027 WRAP, araddr=0x10C, arlen=3, arsize=2 -> mem_addr 0x10C, 0x100, 0x104, 0x108.
REQ-028 FIXED, araddr=0x20, arlen=2 with rready low for 5 cycles on beat 1 -> mem_addr 0x20 three times; beat 1 rdata/rid/rlast stable while stalled.
REQ-029 arburst=2'b11, arlen=1 -> 2 beats with SLVERR and rdata 0, no mem_rd_en; araddr=MEM_BASE+MEM_BYTES -> DECERR (OKAY on both cases without AXI4_SLAVE_RD_ERR_CHECK_EN).
REQ-030 areset pulsed during beat 2 of an arlen=7 burst -> rvalid=0 and arready=1 after reset; a new arid=5 burst completes with rid=5.
